// File: rtl/ldpc_wb_chan_hub.sv
// ldpc_wb_chan_hub
//   Wishbone register front end that feeds N_CH LDPC channels. Each channel
//   has a write FIFO streamed over valid/ready, plus control, sticky status
//   and interrupt-mask registers. All interrupt sources are OR-ed into irq_o.
//
// Ports
//   wb_clk_i, wb_rst_ni    clock, asynchronous active-low reset
//   wbs_*                  Wishbone slave (classic, 2-cycle access)
//   ch_tdata_o/tvalid_o    per-channel FIFO head word and valid
//   ch_tready_i            per-channel core accept
//   ch_done_i/ch_err_i     per-channel one-cycle event pulses
//   irq_o                  aggregated, registered interrupt
//
// Register map (byte address within block)
//   [7:4] channel, [3:2] register: 0 DATA, 1 CTRL, 2 STATUS, 3 IMASK
module ldpc_wb_chan_hub #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter logic [31:0] ADR_MASK   = 32'hFFFF_FF00
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [32*N_CH-1:0]  ch_tdata_o,
    output logic [N_CH-1:0]     ch_tvalid_o,
    input  logic [N_CH-1:0]     ch_tready_i,
    input  logic [N_CH-1:0]     ch_done_i,
    input  logic [N_CH-1:0]     ch_err_i,
    output logic                irq_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;

    logic             r_ack;
    logic [31:0]      r_rdata;
    logic             r_irq;
    logic             w_hit;
    logic             w_req;
    logic             w_wr;
    logic [3:0]       w_ch;
    logic [1:0]       w_reg;
    logic [31:0]      w_rd_ch [N_CH];
    logic [31:0]      w_rdval;
    logic [N_CH-1:0]  w_irq_ch;

    assign w_hit = (wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK);
    assign w_req = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    // Writes commit on the edge that closes the ack cycle, using the bus
    // values the master is still holding.
    assign w_wr  = r_ack & wbs_cyc_i & wbs_stb_i & w_hit & wbs_we_i;
    assign w_ch  = wbs_adr_i[7:4];
    assign w_reg = wbs_adr_i[3:2];

    // Channels beyond N_CH read as zero.
    always_comb begin
        w_rdval = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_ch == 4'(i)) w_rdval = w_rd_ch[i];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !wbs_we_i) ? w_rdval : '0;
            r_irq   <= |w_irq_ch;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdata;
    assign irq_o     = r_irq;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [31:0]   r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_rd, r_wr;
        logic [LW-1:0] r_lvl;
        logic          r_en, r_done, r_err, r_ovf;
        logic [2:0]    r_mask;
        logic [31:0]   r_tdata;

        logic          w_sel_ch, w_push_req, w_ctrl_wr, w_stat_wr, w_mask_wr;
        logic          w_flush, w_full, w_empty, w_valid, w_pop, w_push, w_rej;
        logic [AW-1:0] w_rd_nx, w_wr_nx;
        logic [LW-1:0] w_lvl_nx;
        logic          w_done_nx, w_err_nx, w_ovf_nx;
        logic [2:0]    w_mask_nx;
        logic [31:0]   w_head_nx;
        logic [31:0]   w_rd;

        assign w_sel_ch   = w_wr && (w_ch == 4'(c));
        assign w_push_req = w_sel_ch && (w_reg == 2'd0) && (wbs_sel_i == 4'hF);
        assign w_ctrl_wr  = w_sel_ch && (w_reg == 2'd1) && wbs_sel_i[0];
        assign w_stat_wr  = w_sel_ch && (w_reg == 2'd2) && wbs_sel_i[0];
        assign w_mask_wr  = w_sel_ch && (w_reg == 2'd3) && wbs_sel_i[0];
        assign w_flush    = w_ctrl_wr && wbs_dat_i[1];

        assign w_full  = (r_lvl == LW'(FIFO_DEPTH));
        assign w_empty = (r_lvl == '0);
        assign w_valid = r_en & ~w_empty;
        assign w_pop   = w_valid & ch_tready_i[c];
        assign w_push  = w_push_req & (~w_full | w_pop);
        assign w_rej   = w_push_req & ~w_push;

        assign w_rd_nx  = w_flush ? '0 : r_rd + AW'(w_pop);
        assign w_wr_nx  = w_flush ? '0 : r_wr + AW'(w_push);
        assign w_lvl_nx = w_flush ? '0 : r_lvl + LW'(w_push) - LW'(w_pop);

        // Sticky bits: a same-cycle event overrides the W1C clear.
        assign w_done_nx = ch_done_i[c] | (r_done & ~(w_stat_wr & wbs_dat_i[0]));
        assign w_err_nx  = ch_err_i[c]  | (r_err  & ~(w_stat_wr & wbs_dat_i[1]));
        assign w_ovf_nx  = w_rej        | (r_ovf  & ~(w_stat_wr & wbs_dat_i[4]));
        assign w_mask_nx = w_mask_wr ? wbs_dat_i[2:0] : r_mask;
        assign w_irq_ch[c] = |({w_ovf_nx, w_err_nx, w_done_nx} & w_mask_nx);

        // Registered head: bypass the incoming word when it lands in the
        // slot that becomes the head, otherwise read ahead from memory.
        assign w_head_nx = (w_push && (r_wr == w_rd_nx)) ? wbs_dat_i : r_mem[w_rd_nx];

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
                r_rd    <= '0;
                r_wr    <= '0;
                r_lvl   <= '0;
                r_en    <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_ovf   <= 1'b0;
                r_mask  <= '0;
                r_tdata <= '0;
            end else begin
                if (w_push) r_mem[r_wr] <= wbs_dat_i;
                r_rd    <= w_rd_nx;
                r_wr    <= w_wr_nx;
                r_lvl   <= w_lvl_nx;
                if (w_ctrl_wr) r_en <= wbs_dat_i[0];
                r_done  <= w_done_nx;
                r_err   <= w_err_nx;
                r_ovf   <= w_ovf_nx;
                r_mask  <= w_mask_nx;
                r_tdata <= w_head_nx;
            end
        end

        always_comb begin
            w_rd = '0;
            case (w_reg)
                2'd0: w_rd = 32'(r_lvl);
                2'd1: w_rd = {31'b0, r_en};
                2'd2: w_rd = {16'b0, 8'(r_lvl), 3'b0, r_ovf, w_empty, w_full, r_err, r_done};
                2'd3: w_rd = {29'b0, r_mask};
                default: w_rd = '0;
            endcase
        end

        assign w_rd_ch[c]             = w_rd;
        assign ch_tdata_o[32*c +: 32] = r_tdata;
        assign ch_tvalid_o[c]         = w_valid;
    end

endmodule

// File: tb/tb_ldpc_wb_chan_hub.sv
// Bench for ldpc_wb_chan_hub: directed scenarios plus a randomized phase,
// all checked against a queue-based behavioural model of the register block.
module tb_ldpc_wb_chan_hub;

    localparam int N_CH  = 2;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] AMASK = 32'hFFFF_FF00;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = '0, dat_i = '0;
    logic              ack;
    logic [31:0]       dat_o;
    logic [32*N_CH-1:0] tdata;
    logic [N_CH-1:0]   tvalid;
    logic [N_CH-1:0]   tready = '0, done = '0, err = '0;
    logic              irq;

    ldpc_wb_chan_hub #(
        .N_CH(N_CH), .FIFO_DEPTH(DEPTH), .BASE_ADR(BASE), .ADR_MASK(AMASK)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .ch_tdata_o(tdata), .ch_tvalid_o(tvalid), .ch_tready_i(tready),
        .ch_done_i(done), .ch_err_i(err), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] mq [N_CH][$];
    bit          m_en [N_CH], m_done [N_CH], m_err [N_CH], m_ovf [N_CH];
    bit [2:0]    m_mask [N_CH];
    bit          m_ack, m_irq, m_hit;
    int          m_wc;
    bit [N_CH-1:0] m_pop;

    function automatic logic [31:0] exp_read(input logic [3:0] ch, input logic [1:0] rg);
        int c;
        int lvl;
        c = int'(ch);
        if (c >= N_CH) return 32'h0;
        lvl = mq[c].size();
        case (rg)
            2'd0: return 32'(lvl);
            2'd1: return m_en[c] ? 32'd1 : 32'd0;
            2'd2: return 32'(lvl * 256 + int'(m_ovf[c]) * 16 + int'(lvl == 0) * 8
                         + int'(lvl == DEPTH) * 4 + int'(m_err[c]) * 2 + int'(m_done[c]));
            default: return 32'(m_mask[c]);
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < N_CH; i++) begin
                    mq[i].delete();
                    m_en[i] = 0; m_done[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_mask[i] = 0;
                end
                m_ack = 0;
                m_irq = 0;
            end else begin
                m_hit = (adr & AMASK) == (BASE & AMASK);
                for (int i = 0; i < N_CH; i++)
                    m_pop[i] = m_en[i] && (mq[i].size() > 0) && tready[i];
                for (int i = 0; i < N_CH; i++)
                    if (m_pop[i]) void'(mq[i].pop_front());
                if (m_ack && cyc && stb && we && m_hit) begin
                    m_wc = int'(adr[7:4]);
                    if (m_wc < N_CH) begin
                        case (adr[3:2])
                            2'd0: if (sel == 4'hF) begin
                                if (mq[m_wc].size() < DEPTH) mq[m_wc].push_back(dat_i);
                                else m_ovf[m_wc] = 1;
                            end
                            2'd1: if (sel[0]) begin
                                m_en[m_wc] = dat_i[0];
                                if (dat_i[1]) mq[m_wc].delete();
                            end
                            2'd2: if (sel[0]) begin
                                if (dat_i[0]) m_done[m_wc] = 0;
                                if (dat_i[1]) m_err[m_wc] = 0;
                                if (dat_i[4]) m_ovf[m_wc] = 0;
                            end
                            default: if (sel[0]) m_mask[m_wc] = dat_i[2:0];
                        endcase
                    end
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (done[i]) m_done[i] = 1;
                    if (err[i])  m_err[i]  = 1;
                end
                m_irq = 0;
                for (int i = 0; i < N_CH; i++)
                    m_irq = m_irq | (m_done[i] & m_mask[i][0]) | (m_err[i] & m_mask[i][1])
                                  | (m_ovf[i] & m_mask[i][2]);
                m_ack = cyc && stb && m_hit && !m_ack;
            end
        end
    end

    // ---------------- bus driver (no checking) ----------------
    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic acked, output logic [31:0] xrd);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
        xrd = exp_read(a[7:4], a[3:2]);
        @(posedge clk); #1;
        acked = ack;
        rd = dat_o;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    logic [31:0] rd, xrd;
    logic        acked;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        vec++; if (ack !== 1'b0)   begin errs++; $display("FAIL reset_ack: got %0b want 0", ack); end
        vec++; if (dat_o !== '0)   begin errs++; $display("FAIL reset_dat: got %h want 0", dat_o); end
        vec++; if (tvalid !== '0)  begin errs++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
        vec++; if (tdata !== '0)   begin errs++; $display("FAIL reset_tdata: got %h want 0", tdata); end
        vec++; if (irq !== 1'b0)   begin errs++; $display("FAIL reset_irq: got %0b want 0", irq); end
        wb_xfer(0, 32'h3000_0008, 0, 4'hF, rd, acked, xrd);
        vec++; if (acked !== 1'b1) begin errs++; $display("FAIL reset_rd_ack: got %0b want 1", acked); end
        vec++; if (rd !== 32'h8)   begin errs++; $display("FAIL reset_status: got %h want 00000008", rd); end
        vec++; if (ack !== 1'b0 || dat_o !== '0)
            begin errs++; $display("FAIL ack_one_cycle: ack %0b dat %h want 0/0", ack, dat_o); end
    endtask

    task automatic test_fill_ovf();
        logic [31:0] w [DEPTH];
        tready = '0;
        wb_xfer(1, 32'h3000_0014, 32'h1, 4'hF, rd, acked, xrd);
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = $urandom;
            wb_xfer(1, 32'h3000_0010, w[i], 4'hF, rd, acked, xrd);
            vec++; if (tvalid[1] !== 1'b1 || tdata[63:32] !== w[0])
                begin errs++; $display("FAIL fill_head[%0d]: valid %0b data %h want 1/%h", i, tvalid[1], tdata[63:32], w[0]); end
        end
        wb_xfer(0, 32'h3000_0018, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h0804) begin errs++; $display("FAIL full_status: got %h want 00000804", rd); end
        wb_xfer(1, 32'h3000_0010, $urandom, 4'hF, rd, acked, xrd);
        wb_xfer(0, 32'h3000_0018, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h0814 || rd !== xrd)
            begin errs++; $display("FAIL ovf_status: got %h want 00000814 (model %h)", rd, xrd); end
        @(negedge clk);
        tready = 2'b10;
        for (int i = 0; i < DEPTH; i++) begin
            vec++; if (tvalid[1] !== 1'b1 || tdata[63:32] !== w[i])
                begin errs++; $display("FAIL drain[%0d]: valid %0b data %h want 1/%h", i, tvalid[1], tdata[63:32], w[i]); end
            @(negedge clk);
        end
        vec++; if (tvalid[1] !== 1'b0) begin errs++; $display("FAIL drain_end: valid %0b want 0", tvalid[1]); end
        tready = '0;
    endtask

    task automatic test_irq();
        wb_xfer(1, 32'h3000_000C, 32'h1, 4'hF, rd, acked, xrd);
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_idle: got %0b want 0", irq); end
        @(negedge clk); done = 2'b01;
        @(negedge clk); done = 2'b00;
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set: got %0b want 1", irq); end
        wb_xfer(1, 32'h3000_0008, 32'h1, 4'hF, rd, acked, xrd);
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_clear: got %0b want 0", irq); end
        // DONE pulse lands in the W1C ack cycle
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_0008; dat_i = 32'h1; sel = 4'hF;
        @(posedge clk); #1; done = 2'b01;
        @(posedge clk); #1; done = 2'b00; cyc = 0; stb = 0; we = 0;
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_setwins: got %0b want 1", irq); end
        wb_xfer(0, 32'h3000_0008, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h9) begin errs++; $display("FAIL done_sticky: got %h want 00000009", rd); end
        wb_xfer(1, 32'h3000_0008, 32'h1, 4'hF, rd, acked, xrd);
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_clear2: got %0b want 0", irq); end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] w [DEPTH+1];
        tready = '0;
        wb_xfer(1, 32'h3000_0004, 32'h1, 4'hF, rd, acked, xrd);
        for (int i = 0; i <= DEPTH; i++) w[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) wb_xfer(1, 32'h3000_0000, w[i], 4'hF, rd, acked, xrd);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_0000; dat_i = w[DEPTH]; sel = 4'hF;
        @(posedge clk); #1; tready = 2'b01;
        @(posedge clk); #1; tready = 2'b00; cyc = 0; stb = 0; we = 0;
        wb_xfer(0, 32'h3000_0008, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h0804) begin errs++; $display("FAIL pushpop_status: got %h want 00000804", rd); end
        @(negedge clk);
        tready = 2'b01;
        for (int i = 1; i <= DEPTH; i++) begin
            vec++; if (tvalid[0] !== 1'b1 || tdata[31:0] !== w[i])
                begin errs++; $display("FAIL pushpop_order[%0d]: valid %0b data %h want 1/%h", i, tvalid[0], tdata[31:0], w[i]); end
            @(negedge clk);
        end
        vec++; if (tvalid[0] !== 1'b0) begin errs++; $display("FAIL pushpop_end: valid %0b want 0", tvalid[0]); end
        tready = '0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) wb_xfer(1, 32'h3000_0000, $urandom, 4'hF, rd, acked, xrd);
        vec++; if (tvalid[0] !== 1'b1) begin errs++; $display("FAIL flush_pre: valid %0b want 1", tvalid[0]); end
        wb_xfer(1, 32'h3000_0004, 32'h3, 4'hF, rd, acked, xrd);
        vec++; if (tvalid[0] !== 1'b0) begin errs++; $display("FAIL flush_valid: got %0b want 0", tvalid[0]); end
        wb_xfer(0, 32'h3000_0000, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h0) begin errs++; $display("FAIL flush_level: got %h want 0", rd); end
        wb_xfer(1, 32'h3000_0000, $urandom, 4'h3, rd, acked, xrd);
        vec++; if (acked !== 1'b1) begin errs++; $display("FAIL partsel_ack: got %0b want 1", acked); end
        wb_xfer(0, 32'h3000_0000, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h0) begin errs++; $display("FAIL partsel_level: got %h want 0", rd); end
        wb_xfer(0, 32'h3000_0004, 0, 4'hF, rd, acked, xrd);
        vec++; if (rd !== 32'h1) begin errs++; $display("FAIL ctrl_read: got %h want 00000001", rd); end
    endtask

    task automatic test_decode();
        wb_xfer(0, 32'h3000_0050, 0, 4'hF, rd, acked, xrd);
        vec++; if (acked !== 1'b1 || rd !== 32'h0)
            begin errs++; $display("FAIL badch: ack %0b data %h want 1/0", acked, rd); end
        wb_xfer(1, 32'h3000_0050, 32'hFFFF_FFFF, 4'hF, rd, acked, xrd);
        vec++; if (acked !== 1'b1) begin errs++; $display("FAIL badch_wr: ack %0b want 1", acked); end
        wb_xfer(0, 32'h3000_0100, 0, 4'hF, rd, acked, xrd);
        vec++; if (acked !== 1'b0 || ack !== 1'b0)
            begin errs++; $display("FAIL miss: ack %0b/%0b want 0/0", acked, ack); end
    endtask

    task automatic test_reset_mid();
        wb_xfer(1, 32'h3000_0000, $urandom, 4'hF, rd, acked, xrd);
        wb_xfer(1, 32'h3000_0000, $urandom, 4'hF, rd, acked, xrd);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0008; sel = 4'hF;
        @(posedge clk); #1;
        vec++; if (ack !== 1'b1) begin errs++; $display("FAIL mid_ack: got %0b want 1", ack); end
        #2 rst_n = 0;
        #1;
        vec++; if (ack !== 1'b0 || dat_o !== '0)
            begin errs++; $display("FAIL mid_reset_bus: ack %0b dat %h want 0/0", ack, dat_o); end
        vec++; if (tvalid !== '0 || tdata !== '0 || irq !== 1'b0)
            begin errs++; $display("FAIL mid_reset_state: valid %b data %h irq %0b want 0", tvalid, tdata, irq); end
        cyc = 0; stb = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_random();
        int op;
        logic [31:0] a;
        logic [3:0] s;
        bit w;
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                tready[c] = ($urandom_range(0, 3) == 0);
                done[c]   = ($urandom_range(0, 7) == 0);
                err[c]    = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            done = '0; err = '0;
            for (int c = 0; c < N_CH; c++) begin
                vec++; if (tvalid[c] !== (m_en[c] && mq[c].size() > 0))
                    begin errs++; $display("FAIL rnd_valid[%0d] ch%0d: got %0b want %0b", it, c, tvalid[c], m_en[c] && mq[c].size() > 0); end
                if (m_en[c] && mq[c].size() > 0) begin
                    vec++; if (tdata[32*c +: 32] !== mq[c][0])
                        begin errs++; $display("FAIL rnd_data[%0d] ch%0d: got %h want %h", it, c, tdata[32*c +: 32], mq[c][0]); end
                end
            end
            vec++; if (irq !== m_irq) begin errs++; $display("FAIL rnd_irq[%0d]: got %0b want %0b", it, irq, m_irq); end
            op = $urandom_range(0, 9);
            a  = BASE | (32'($urandom_range(0, 2)) << 4);
            s  = 4'hF;
            w  = 1;
            dat_i = '0;
            case (op)
                0, 1, 2, 3, 4: begin
                    if ($urandom_range(0, 5) == 0) s = 4'($urandom);
                    wb_xfer(1, a, $urandom, s, rd, acked, xrd);
                end
                6: wb_xfer(1, a | 32'h4, {30'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)}, s, rd, acked, xrd);
                7: wb_xfer(1, a | 32'h8, 32'($urandom) & 32'h13, s, rd, acked, xrd);
                8: wb_xfer(1, a | 32'hC, 32'($urandom_range(0, 7)), s, rd, acked, xrd);
                default: begin
                    w = 0;
                    wb_xfer(0, a | (32'($urandom_range(0, 3)) << 2), 0, s, rd, acked, xrd);
                end
            endcase
            vec++; if (acked !== 1'b1) begin errs++; $display("FAIL rnd_ack[%0d]: got %0b want 1", it, acked); end
            vec++; if (rd !== (w ? 32'h0 : xrd))
                begin errs++; $display("FAIL rnd_rdata[%0d] adr %h: got %h want %h", it, adr, rd, w ? 32'h0 : xrd); end
        end
        tready = '0;
    endtask

    initial begin
        test_reset();
        test_fill_ovf();
        test_irq();
        test_full_pushpop();
        test_flush();
        test_decode();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
